mem_cont_pipelined: RTL and testbench

//  Parametrised memory controller between dataflow load/store ports and a single-port BRAM with

---
 rtl/mem_cont_pipelined_if.sv | 51 +++++
 rtl/mem_cont_pipelined.sv | 176 +++++++++++++++++
 tb/tb_mem_cont_pipelined.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cont_pipelined_if.sv
// Bundle of the memory-bus, load/store port and basic-block signals of mem_cont_pipelined.
// master = controller side, slave = dataflow/memory environment side.
interface mem_cont_pipelined_if #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int BB_COUNT     = 1,
  parameter int LOAD_COUNT   = 1,
  parameter int STORE_COUNT  = 1
);
  logic [DATA_SIZE-1:0]                io_storeDataOut;
  logic [ADDRESS_SIZE-1:0]             io_storeAddrOut;
  logic                                io_storeEnable;
  logic [DATA_SIZE-1:0]                io_loadDataIn;
  logic [ADDRESS_SIZE-1:0]             io_loadAddrOut;
  logic                                io_loadEnable;
  logic [BB_COUNT-1:0]                 io_bbpValids;
  logic [BB_COUNT*32-1:0]              io_bb_stCountArray;
  logic [BB_COUNT-1:0]                 io_bbReadyToPrevs;
  logic                                io_Empty_Valid;
  logic                                io_Empty_Ready;
  logic [LOAD_COUNT-1:0]               io_rdPortsPrev_valid;
  logic [LOAD_COUNT*ADDRESS_SIZE-1:0]  io_rdPortsPrev_bits;
  logic [LOAD_COUNT-1:0]               io_rdPortsPrev_ready;
  logic [LOAD_COUNT-1:0]               io_rdPortsNext_valid;
  logic [LOAD_COUNT*DATA_SIZE-1:0]     io_rdPortsNext_bits;
  logic [LOAD_COUNT-1:0]               io_rdPortsNext_ready;
  logic [STORE_COUNT-1:0]              io_wrAddrPorts_valid;
  logic [STORE_COUNT*ADDRESS_SIZE-1:0] io_wrAddrPorts_bits;
  logic [STORE_COUNT-1:0]              io_wrAddrPorts_ready;
  logic [STORE_COUNT-1:0]              io_wrDataPorts_valid;
  logic [STORE_COUNT*DATA_SIZE-1:0]    io_wrDataPorts_bits;
  logic [STORE_COUNT-1:0]              io_wrDataPorts_ready;

  modport master (
    output io_storeDataOut, io_storeAddrOut, io_storeEnable, io_loadAddrOut, io_loadEnable,
           io_bbReadyToPrevs, io_Empty_Valid, io_rdPortsPrev_ready, io_rdPortsNext_valid,
           io_rdPortsNext_bits, io_wrAddrPorts_ready, io_wrDataPorts_ready,
    input  io_loadDataIn, io_bbpValids, io_bb_stCountArray, io_Empty_Ready,
           io_rdPortsPrev_valid, io_rdPortsPrev_bits, io_rdPortsNext_ready,
           io_wrAddrPorts_valid, io_wrAddrPorts_bits, io_wrDataPorts_valid, io_wrDataPorts_bits
  );

  modport slave (
    input  io_storeDataOut, io_storeAddrOut, io_storeEnable, io_loadAddrOut, io_loadEnable,
           io_bbReadyToPrevs, io_Empty_Valid, io_rdPortsPrev_ready, io_rdPortsNext_valid,
           io_rdPortsNext_bits, io_wrAddrPorts_ready, io_wrDataPorts_ready,
    output io_loadDataIn, io_bbpValids, io_bb_stCountArray, io_Empty_Ready,
           io_rdPortsPrev_valid, io_rdPortsPrev_bits, io_rdPortsNext_ready,
           io_wrAddrPorts_valid, io_wrAddrPorts_bits, io_wrDataPorts_valid, io_wrDataPorts_bits
  );
endinterface

// File: rtl/mem_cont_pipelined.sv
// Load/store arbiter in front of a fixed-latency single-port BRAM with per-port response buffers
// and pending-store counting. Define MC_RR_ARB_EN for round-robin arbiters (default: fixed priority).
module mem_cont_pipelined #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int BB_COUNT     = 1,
  parameter int LOAD_COUNT   = 1,
  parameter int STORE_COUNT  = 1,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input logic                  clk,
  input logic                  rst,
  mem_cont_pipelined_if.master bus
);
  localparam int LIDX_W = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;
  localparam int SIDX_W = (STORE_COUNT > 1) ? $clog2(STORE_COUNT) : 1;

  logic [LOAD_COUNT-1:0]  ld_elig, ld_grant, inflight, next_vld;
  logic [LIDX_W-1:0]      ld_idx;
  logic [STORE_COUNT-1:0] st_elig, st_grant;
  logic [SIDX_W-1:0]      st_idx;
  logic [CNT_WIDTH-1:0]   cnt, cnt_add;
  logic [DATA_SIZE-1:0]   resp [LOAD_COUNT];
  logic                   tag_vld_p [READ_LATENCY];
  logic [LIDX_W-1:0]      tag_idx_p [READ_LATENCY];
  logic                   land_vld;
  logic [LIDX_W-1:0]      land_idx;
  logic                   unused_empty_ready;

  // The store count never wraps below zero.
  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v, input logic dec);
    if (dec && (v != '0)) return v - CNT_WIDTH'(1);
    return v;
  endfunction

  // A port may only be granted once its previous response has been (or is being) consumed.
  assign ld_elig = bus.io_rdPortsPrev_valid & ~inflight & (~next_vld | bus.io_rdPortsNext_ready);
  assign st_elig = bus.io_wrAddrPorts_valid & bus.io_wrDataPorts_valid;

`ifdef MC_RR_ARB_EN
  logic [LIDX_W-1:0] ld_ptr;
  logic [SIDX_W-1:0] st_ptr;

  // Scan farthest-to-nearest from the pointer so the nearest eligible port is the last to win.
  always_comb begin
    ld_grant = '0;
    ld_idx   = '0;
    st_grant = '0;
    st_idx   = '0;
    if (!rst) begin
      for (int off = LOAD_COUNT; off >= 1; off--) begin
        if (ld_elig[LIDX_W'((int'(ld_ptr) + off) % LOAD_COUNT)]) begin
          ld_grant = '0;
          ld_grant[LIDX_W'((int'(ld_ptr) + off) % LOAD_COUNT)] = 1'b1;
          ld_idx = LIDX_W'((int'(ld_ptr) + off) % LOAD_COUNT);
        end
      end
      for (int off = STORE_COUNT; off >= 1; off--) begin
        if (st_elig[SIDX_W'((int'(st_ptr) + off) % STORE_COUNT)]) begin
          st_grant = '0;
          st_grant[SIDX_W'((int'(st_ptr) + off) % STORE_COUNT)] = 1'b1;
          st_idx = SIDX_W'((int'(st_ptr) + off) % STORE_COUNT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ptr <= LIDX_W'(LOAD_COUNT - 1);
      st_ptr <= SIDX_W'(STORE_COUNT - 1);
    end else begin
      if (|ld_grant) ld_ptr <= ld_idx;
      if (|st_grant) st_ptr <= st_idx;
    end
  end
`else
  always_comb begin
    ld_grant = '0;
    ld_idx   = '0;
    st_grant = '0;
    st_idx   = '0;
    if (!rst) begin
      for (int k = LOAD_COUNT - 1; k >= 0; k--) begin
        if (ld_elig[k]) begin
          ld_grant    = '0;
          ld_grant[k] = 1'b1;
          ld_idx      = LIDX_W'(k);
        end
      end
      for (int k = STORE_COUNT - 1; k >= 0; k--) begin
        if (st_elig[k]) begin
          st_grant    = '0;
          st_grant[k] = 1'b1;
          st_idx      = SIDX_W'(k);
        end
      end
    end
  end
`endif

  assign bus.io_loadEnable        = |ld_grant;
  assign bus.io_loadAddrOut       = (|ld_grant) ?
      bus.io_rdPortsPrev_bits[int'(ld_idx)*ADDRESS_SIZE +: ADDRESS_SIZE] : '0;
  assign bus.io_rdPortsPrev_ready = ld_grant;
  assign bus.io_storeEnable       = |st_grant;
  assign bus.io_storeAddrOut      = (|st_grant) ?
      bus.io_wrAddrPorts_bits[int'(st_idx)*ADDRESS_SIZE +: ADDRESS_SIZE] : '0;
  assign bus.io_storeDataOut      = (|st_grant) ?
      bus.io_wrDataPorts_bits[int'(st_idx)*DATA_SIZE +: DATA_SIZE] : '0;
  assign bus.io_wrAddrPorts_ready = st_grant;
  assign bus.io_wrDataPorts_ready = st_grant;

  // Tag pipeline: stage k holds the request issued k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) tag_vld_p[k] <= 1'b0;
    end else begin
      tag_vld_p[0] <= |ld_grant;
      for (int k = 1; k < READ_LATENCY; k++) tag_vld_p[k] <= tag_vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_idx_p[0] <= ld_idx;
    for (int k = 1; k < READ_LATENCY; k++) tag_idx_p[k] <= tag_idx_p[k-1];
  end

  assign land_vld = tag_vld_p[READ_LATENCY-1];
  assign land_idx = tag_idx_p[READ_LATENCY-1];

  // A landing response takes priority over the consume that would clear next_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      next_vld <= '0;
    end else begin
      for (int i = 0; i < LOAD_COUNT; i++) begin
        if (land_vld && (land_idx == LIDX_W'(i))) begin
          next_vld[i] <= 1'b1;
          inflight[i] <= 1'b0;
        end else begin
          if (next_vld[i] && bus.io_rdPortsNext_ready[i]) next_vld[i] <= 1'b0;
          if (ld_grant[i]) inflight[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (land_vld) resp[land_idx] <= bus.io_loadDataIn;
  end

  assign bus.io_rdPortsNext_valid = next_vld;
  for (genvar g = 0; g < LOAD_COUNT; g++) begin : g_next_bits
    assign bus.io_rdPortsNext_bits[g*DATA_SIZE +: DATA_SIZE] = resp[g];
  end

  always_comb begin
    cnt_add = '0;
    for (int b = 0; b < BB_COUNT; b++) begin
      if (bus.io_bbpValids[b]) cnt_add = cnt_add + CNT_WIDTH'(bus.io_bb_stCountArray[b*32 +: 32]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= sat_dec(cnt + cnt_add, |st_grant);
  end

  assign bus.io_Empty_Valid    = (cnt == '0) && (bus.io_bbpValids == '0);
  assign bus.io_bbReadyToPrevs = '1;
  assign unused_empty_ready    = bus.io_Empty_Ready;

endmodule

// File: tb/tb_mem_cont_pipelined.sv
// Directed bench for mem_cont_pipelined: 3 load ports, 2 store ports, 2 BBs, read latency 2.
// Arbitration expectations follow MC_RR_ARB_EN when it is defined.
module tb_mem_cont_pipelined;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_cont_pipelined_if #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .BB_COUNT(2),
                          .LOAD_COUNT(3), .STORE_COUNT(2)) bus ();

  mem_cont_pipelined #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .BB_COUNT(2), .LOAD_COUNT(3),
                       .STORE_COUNT(2), .READ_LATENCY(2), .CNT_WIDTH(32))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in: returns addr+0x9B two cycles after the enable.
  logic [31:0] mem_p0 = 32'h0;
  logic [31:0] mem_p1 = 32'h0;
  always @(posedge clk) begin
    mem_p0 <= bus.io_loadEnable ? bus.io_loadAddrOut + 32'h9B : 32'h0;
    mem_p1 <= mem_p0;
  end
  assign bus.io_loadDataIn = mem_p1;

`ifdef MC_RR_ARB_EN
  logic [2:0]  arb_exp [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0]  st2_rdy = 2'b10;
  logic [31:0] st2_addr = 32'h50;
  logic [31:0] st2_data = 32'hD1;
`else
  logic [2:0]  arb_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0]  st2_rdy = 2'b01;
  logic [31:0] st2_addr = 32'h40;
  logic [31:0] st2_data = 32'hD0;
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.io_bbpValids         = '0;
    bus.io_bb_stCountArray   = '0;
    bus.io_Empty_Ready       = 1'b1;
    bus.io_rdPortsPrev_valid = 3'b111;
    bus.io_rdPortsPrev_bits  = {32'h300, 32'h200, 32'h100};
    bus.io_rdPortsNext_ready = '0;
    bus.io_wrAddrPorts_valid = 2'b11;
    bus.io_wrAddrPorts_bits  = {32'h50, 32'h40};
    bus.io_wrDataPorts_valid = 2'b11;
    bus.io_wrDataPorts_bits  = {32'hD1, 32'hD0};
    nxt();
    mid();
    check("rst_load_en", 64'(bus.io_loadEnable), 64'd0);
    check("rst_prev_rdy", 64'(bus.io_rdPortsPrev_ready), 64'd0);
    check("rst_store_en", 64'(bus.io_storeEnable), 64'd0);
    check("rst_wr_rdy", 64'(bus.io_wrAddrPorts_ready), 64'd0);
    check("rst_next_vld", 64'(bus.io_rdPortsNext_valid), 64'd0);
    check("rst_empty", 64'(bus.io_Empty_Valid), 64'd1);
    check("bb_ready", 64'(bus.io_bbReadyToPrevs), 64'd3);
    nxt();
    bus.io_rdPortsPrev_valid = '0;
    bus.io_wrAddrPorts_valid = '0;
    bus.io_wrDataPorts_valid = '0;
    rst = 1'b0;

    // Single load on port 0, then held response while port 1 proceeds.
    bus.io_rdPortsPrev_valid = 3'b001;
    bus.io_rdPortsPrev_bits  = {32'h300, 32'h30, 32'h10};
    mid();
    check("ld1_en", 64'(bus.io_loadEnable), 64'd1);
    check("ld1_addr", 64'(bus.io_loadAddrOut), 64'h10);
    check("ld1_prev_rdy", 64'(bus.io_rdPortsPrev_ready), 64'd1);
    nxt();
    bus.io_rdPortsPrev_bits[31:0] = 32'h20;
    mid();
    check("ld1_outstanding", 64'(bus.io_loadEnable), 64'd0);
    check("ld1_vld_t1", 64'(bus.io_rdPortsNext_valid), 64'd0);
    nxt();
    mid();
    check("ld1_vld_t2", 64'(bus.io_rdPortsNext_valid), 64'd0);
    nxt();
    bus.io_rdPortsPrev_valid = 3'b011;
    mid();
    check("ld1_vld_t3", 64'(bus.io_rdPortsNext_valid), 64'd1);
    check("ld1_data_t3", 64'(bus.io_rdPortsNext_bits[31:0]), 64'hAB);
    check("held_other_en", 64'(bus.io_loadEnable), 64'd1);
    check("held_other_addr", 64'(bus.io_loadAddrOut), 64'h30);
    check("held_other_rdy", 64'(bus.io_rdPortsPrev_ready), 64'd2);
    nxt();
    mid();
    check("held_no_grant", 64'(bus.io_loadEnable), 64'd0);
    check("held_vld", 64'(bus.io_rdPortsNext_valid), 64'd1);
    check("held_data", 64'(bus.io_rdPortsNext_bits[31:0]), 64'hAB);
    nxt();
    bus.io_rdPortsNext_ready = 3'b001;
    mid();
    check("release_en", 64'(bus.io_loadEnable), 64'd1);
    check("release_addr", 64'(bus.io_loadAddrOut), 64'h20);
    check("release_rdy", 64'(bus.io_rdPortsPrev_ready), 64'd1);
    nxt();
    bus.io_rdPortsPrev_valid = '0;
    mid();
    check("p1_land_vld", 64'(bus.io_rdPortsNext_valid), 64'd2);
    check("p1_land_data", 64'(bus.io_rdPortsNext_bits[63:32]), 64'hCB);
    nxt();
    nxt();
    mid();
    check("p0_reload_vld", 64'(bus.io_rdPortsNext_valid), 64'd3);
    check("p0_reload_data", 64'(bus.io_rdPortsNext_bits[31:0]), 64'hBB);
    nxt();
    bus.io_rdPortsNext_ready = 3'b111;
    nxt();

    // All three ports requesting continuously.
    bus.io_rdPortsPrev_valid = 3'b111;
    bus.io_rdPortsPrev_bits  = {32'h300, 32'h200, 32'h100};
    mid();
    check("arb_drained", 64'(bus.io_rdPortsNext_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) mid();
      check($sformatf("arb_grant%0d", i), 64'(bus.io_rdPortsPrev_ready), 64'(arb_exp[i]));
      nxt();
    end
    bus.io_rdPortsPrev_valid = '0;
    nxt();
    nxt();
    nxt();
    mid();
    check("arb_resp0", 64'(bus.io_rdPortsNext_bits[31:0]), 64'h19B);
    check("arb_resp1", 64'(bus.io_rdPortsNext_bits[63:32]), 64'h29B);
    check("arb_resp2", 64'(bus.io_rdPortsNext_bits[95:64]), 64'h39B);
    check("arb_final_vld", 64'(bus.io_rdPortsNext_valid), 64'd0);
    nxt();

    // Stores: only a port with both address and data valid is granted; count stays at 0.
    bus.io_wrAddrPorts_valid = 2'b11;
    bus.io_wrDataPorts_valid = 2'b01;
    mid();
    check("st_en", 64'(bus.io_storeEnable), 64'd1);
    check("st_addr_rdy", 64'(bus.io_wrAddrPorts_ready), 64'd1);
    check("st_data_rdy", 64'(bus.io_wrDataPorts_ready), 64'd1);
    check("st_addr", 64'(bus.io_storeAddrOut), 64'h40);
    check("st_data", 64'(bus.io_storeDataOut), 64'hD0);
    nxt();
    bus.io_wrDataPorts_valid = 2'b11;
    mid();
    check("st_zero_empty", 64'(bus.io_Empty_Valid), 64'd1);
    check("st2_rdy", 64'(bus.io_wrDataPorts_ready), 64'(st2_rdy));
    check("st2_addr", 64'(bus.io_storeAddrOut), 64'(st2_addr));
    check("st2_data", 64'(bus.io_storeDataOut), 64'(st2_data));
    nxt();
    bus.io_wrAddrPorts_valid = '0;
    bus.io_wrDataPorts_valid = '0;
    mid();
    check("st_idle_en", 64'(bus.io_storeEnable), 64'd0);
    check("st_idle_empty", 64'(bus.io_Empty_Valid), 64'd1);
    nxt();

    // Pending-store count: BB0 announces 3 stores (BB1 slice ignored while its valid is low).
    bus.io_bbpValids       = 2'b01;
    bus.io_bb_stCountArray = {32'd5, 32'd3};
    mid();
    check("cnt_bbp_empty", 64'(bus.io_Empty_Valid), 64'd0);
    nxt();
    bus.io_bbpValids         = '0;
    bus.io_wrAddrPorts_valid = 2'b01;
    bus.io_wrDataPorts_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("cnt_store%0d_empty", i), 64'(bus.io_Empty_Valid), 64'd0);
      nxt();
    end
    bus.io_wrAddrPorts_valid = '0;
    bus.io_wrDataPorts_valid = '0;
    mid();
    check("cnt_done_empty", 64'(bus.io_Empty_Valid), 64'd1);
    nxt();

    // Two BBs in one cycle (2+1) plus a simultaneous store -> 2 pending.
    bus.io_bbpValids         = 2'b11;
    bus.io_bb_stCountArray   = {32'd1, 32'd2};
    bus.io_wrAddrPorts_valid = 2'b01;
    bus.io_wrDataPorts_valid = 2'b01;
    nxt();
    bus.io_bbpValids = '0;
    mid();
    check("sum_cnt2_empty", 64'(bus.io_Empty_Valid), 64'd0);
    nxt();
    mid();
    check("sum_cnt1_empty", 64'(bus.io_Empty_Valid), 64'd0);
    nxt();
    bus.io_wrAddrPorts_valid = '0;
    bus.io_wrDataPorts_valid = '0;
    mid();
    check("sum_done_empty", 64'(bus.io_Empty_Valid), 64'd1);
    nxt();

    // Reset while a load is in flight: its data must be dropped.
    bus.io_rdPortsNext_ready = '0;
    bus.io_rdPortsPrev_valid = 3'b001;
    bus.io_rdPortsPrev_bits  = {32'h300, 32'h200, 32'h60};
    mid();
    check("rf_grant", 64'(bus.io_loadEnable), 64'd1);
    nxt();
    rst = 1'b1;
    mid();
    check("rf_rst_en", 64'(bus.io_loadEnable), 64'd0);
    nxt();
    rst = 1'b0;
    bus.io_rdPortsPrev_valid = '0;
    mid();
    check("rf_vld_a", 64'(bus.io_rdPortsNext_valid), 64'd0);
    nxt();
    mid();
    check("rf_vld_b", 64'(bus.io_rdPortsNext_valid), 64'd0);
    nxt();
    bus.io_rdPortsPrev_valid = 3'b001;
    bus.io_rdPortsPrev_bits  = {32'h300, 32'h200, 32'h70};
    mid();
    check("post_rst_grant", 64'(bus.io_loadEnable), 64'd1);
    check("post_rst_addr", 64'(bus.io_loadAddrOut), 64'h70);
    nxt();
    bus.io_rdPortsPrev_valid = '0;
    nxt();
    nxt();
    mid();
    check("post_rst_vld", 64'(bus.io_rdPortsNext_valid), 64'd1);
    check("post_rst_data", 64'(bus.io_rdPortsNext_bits[31:0]), 64'h10B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
